// File: rtl/conn_setup_sequencer.sv
// Round-robin front end for the RPC connection-setup port: grants one requester,
// serializes its open/close descriptor into setup frames, then returns status.
module conn_setup_sequencer #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CONN_ID_W = 16,
  parameter int unsigned FLOW_W    = 8,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init_done_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ-1:0]            req_open_in,
  input  logic [NUM_REQ*CONN_ID_W-1:0]  req_conn_id_in,
  input  logic [NUM_REQ*32-1:0]         req_dest_ip_in,
  input  logic [NUM_REQ*16-1:0]         req_dest_port_in,
  input  logic [NUM_REQ*FLOW_W-1:0]     req_flow_id_in,
  input  logic [NUM_REQ*16-1:0]         req_qp_num_in,
  input  logic [NUM_REQ*16-1:0]         req_p_key_in,
  input  logic [NUM_REQ*32-1:0]         req_q_key_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic                          rsp_err_out,
  output logic                          setup_en_out,
  output logic [3:0]                    setup_cmd_out,
  output logic [31:0]                   setup_data_out,
  input  logic                          status_valid_in,
  input  logic                          status_err_in,
  input  logic                          parse_err_in,
  output logic                          busy_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] CMD_CONN_ID   = 4'd0;
  localparam logic [3:0] CMD_OPEN      = 4'd1;
  localparam logic [3:0] CMD_DEST_IP   = 4'd2;
  localparam logic [3:0] CMD_DEST_PORT = 4'd3;
  localparam logic [3:0] CMD_FLOW_ID   = 4'd4;
  localparam logic [3:0] CMD_QP_FIELDS = 4'd5;
  localparam logic [3:0] CMD_Q_KEY     = 4'd6;
  localparam logic [3:0] CMD_ENABLE    = 4'd7;

  typedef enum logic [2:0] {StIdle, StGrant, StEmit, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d, winner_q, winner_d, pick, cand;
  logic                 found;
  logic [2:0]           idx_q, idx_d, last_idx;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 perr_q, perr_d, parse_q, err_q, err_d, latch_en, parse_rise;
  logic [3:0]           cmd;

  logic                 open_q;
  logic [CONN_ID_W-1:0] conn_q;
  logic [31:0]          ip_q, qkey_q;
  logic [15:0]          port_q, qp_q, pkey_q;
  logic [FLOW_W-1:0]    flow_q;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = rr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_q) + i) % NUM_REQ);
      if (!found && req_valid_in[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Open frames map index straight to command; close skips to Enable after Open.
  always_comb begin
    last_idx = open_q ? 3'd7 : 3'd2;
    if (open_q || idx_q < 3'd2) cmd = {1'b0, idx_q};
    else                        cmd = CMD_ENABLE;
  end

  assign parse_rise = parse_err_in & ~parse_q;
  assign busy_out   = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    winner_d       = winner_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    perr_d         = perr_q;
    err_d          = err_q;
    latch_en       = 1'b0;
    req_ready_out  = '0;
    rsp_valid_out  = '0;
    rsp_err_out    = 1'b0;
    setup_en_out   = 1'b0;
    setup_cmd_out  = 4'd0;
    setup_data_out = 32'd0;
    unique case (state_q)
      StIdle: begin
        if (init_done_in && found) begin
          winner_d = pick;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        req_ready_out[winner_q] = 1'b1;
        latch_en = 1'b1;
        rr_d     = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
        idx_d    = 3'd0;
        perr_d   = 1'b0;
        state_d  = StEmit;
      end
      StEmit: begin
        setup_en_out  = 1'b1;
        setup_cmd_out = cmd;
        unique case (cmd)
          CMD_CONN_ID:   setup_data_out = 32'(conn_q);
          CMD_OPEN:      setup_data_out = 32'(open_q);
          CMD_DEST_IP:   setup_data_out = ip_q;
          CMD_DEST_PORT: setup_data_out = 32'(port_q);
          CMD_FLOW_ID:   setup_data_out = 32'(flow_q);
          CMD_QP_FIELDS: setup_data_out = {qp_q, pkey_q};
          CMD_Q_KEY:     setup_data_out = qkey_q;
          CMD_ENABLE:    setup_data_out = 32'd1;
          default:       setup_data_out = 32'd0;
        endcase
        if (parse_rise) perr_d = 1'b1;
        if (idx_q == last_idx) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StWait: begin
        // Status beats both a latched parse error and a coincident timeout.
        if (status_valid_in) begin
          err_d   = status_err_in;
          state_d = StResp;
        end else if (perr_q || parse_rise) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        rsp_valid_out[winner_q] = 1'b1;
        rsp_err_out = err_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_q     <= '0;
      winner_q <= '0;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
      parse_q  <= 1'b0;
      err_q    <= 1'b0;
      open_q   <= 1'b0;
      conn_q   <= '0;
      ip_q     <= 32'd0;
      port_q   <= 16'd0;
      flow_q   <= '0;
      qp_q     <= 16'd0;
      pkey_q   <= 16'd0;
      qkey_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      winner_q <= winner_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
      parse_q  <= parse_err_in;
      err_q    <= err_d;
      if (latch_en) begin
        open_q <= req_open_in[winner_q];
        conn_q <= req_conn_id_in[winner_q*CONN_ID_W +: CONN_ID_W];
        ip_q   <= req_dest_ip_in[winner_q*32 +: 32];
        port_q <= req_dest_port_in[winner_q*16 +: 16];
        flow_q <= req_flow_id_in[winner_q*FLOW_W +: FLOW_W];
        qp_q   <= req_qp_num_in[winner_q*16 +: 16];
        pkey_q <= req_p_key_in[winner_q*16 +: 16];
        qkey_q <= req_q_key_in[winner_q*32 +: 32];
      end
    end
  end

endmodule
